// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush and forwarding control for the 5-stage RV32I core.
// Load-use bubbles and taken-transfer flushes are sequenced by a RUN/BUBBLE/FLUSH FSM.
// HAZARD_FORWARD_EN defined: operand forwarding on, load-use stalls for one bubble.
// HAZARD_FORWARD_EN undefined: forwarding tied off, and any E/M/W RAW hazard stalls.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   Rs1D_i, Rs2D_i          : decode source registers
//   Rs1E_i, Rs2E_i          : execute source registers
//   RdE_i, RdM_i, RdW_i     : destinations in execute, memory and writeback
//   regWrite{E,M,W}_i       : stage writes a register
//   resultSrcE_i            : execute instruction is a load
//   pcSrcE_i                : control transfer taken in execute
//   stallF_o, stallD_o      : hold PC, hold fetch->decode register
//   flushD_o, flushE_o      : clear fetch->decode, decode->execute registers
//   forwardAE_o/forwardBE_o : 00 RD, 10 ALU result M, 01 result W
//   stallCount_o            : saturating count of stallD_o cycles
//   flushCount_o            : saturating count of redirect flushes
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
    input  logic                      regWriteE_i,
    input  logic                      regWriteM_i,
    input  logic                      regWriteW_i,
    input  logic                      resultSrcE_i,
    input  logic                      pcSrcE_i,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic [1:0]                forwardAE_o,
    output logic [1:0]                forwardBE_o,
    output logic [CNT_WIDTH-1:0]      stallCount_o,
    output logic [CNT_WIDTH-1:0]      flushCount_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               r_state;
    state_t               w_next;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic w_redirect;
    logic w_load_use;
    logic w_raw;
    logic w_hazard;
    logic w_stall;
    logic w_flush;
    logic w_unused;

    // Some inputs only matter in one build flavour.
    assign w_unused = ^{Rs1E_i, Rs2E_i, resultSrcE_i,
                        regWriteE_i, w_load_use, w_raw};

    assign w_redirect = pcSrcE_i;

    assign w_load_use = resultSrcE_i && (RdE_i != X0) &&
                        ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

    assign w_raw =
        (regWriteE_i && (RdE_i != X0) &&
         ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i))) ||
        (regWriteM_i && (RdM_i != X0) &&
         ((RdM_i == Rs1D_i) || (RdM_i == Rs2D_i))) ||
        (regWriteW_i && (RdW_i != X0) &&
         ((RdW_i == Rs1D_i) || (RdW_i == Rs2D_i)));

`ifdef HAZARD_FORWARD_EN
    assign w_hazard = w_load_use;
`else
    assign w_hazard = w_raw;
`endif

    // Hazards are only evaluated in RUN; a redirect wins in every state
    // because whatever sits in decode is on the wrong path.
    always_comb begin
        w_stall = 1'b0;
        w_flush = 1'b0;
        w_next  = RUN;
        unique case (r_state)
            RUN: begin
                if (w_redirect) begin
                    w_flush = 1'b1;
                    w_next  = FLUSH;
                end else if (w_hazard) begin
                    w_stall = 1'b1;
`ifdef HAZARD_FORWARD_EN
                    w_next  = BUBBLE;
`else
                    w_next  = RUN;
`endif
                end
            end
            BUBBLE, FLUSH: begin
                if (w_redirect) begin
                    w_flush = 1'b1;
                    w_next  = FLUSH;
                end
            end
            default: w_next = RUN;
        endcase
    end

    assign stallF_o = w_stall && !rst;
    assign stallD_o = w_stall && !rst;
    assign flushD_o = w_flush && !rst;
    assign flushE_o = (w_flush || w_stall) && !rst;

`ifdef HAZARD_FORWARD_EN
    // Memory-stage result is younger than writeback, so it wins.
    always_comb begin
        forwardAE_o = 2'b00;
        if (regWriteM_i && (RdM_i != X0) && (RdM_i == Rs1E_i))
            forwardAE_o = 2'b10;
        else if (regWriteW_i && (RdW_i != X0) && (RdW_i == Rs1E_i))
            forwardAE_o = 2'b01;
    end

    always_comb begin
        forwardBE_o = 2'b00;
        if (regWriteM_i && (RdM_i != X0) && (RdM_i == Rs2E_i))
            forwardBE_o = 2'b10;
        else if (regWriteW_i && (RdW_i != X0) && (RdW_i == Rs2E_i))
            forwardBE_o = 2'b01;
    end
`else
    assign forwardAE_o = 2'b00;
    assign forwardBE_o = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (stallD_o && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flushD_o && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stallCount_o = r_stall_cnt;
    assign flushCount_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a
// cycle-history reference model.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          regWriteE, regWriteM, regWriteW, resultSrcE, pcSrcE;
    logic          stallF, stallD, flushD, flushE;
    logic [1:0]    fwdA, fwdB;
    logic [CW-1:0] stallCnt, flushCnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference history: did the previous cycle take a load-use stall or a redirect.
    bit prev_lu = 0;
    bit prev_rd = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
        .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
        .regWriteE_i(regWriteE), .regWriteM_i(regWriteM),
        .regWriteW_i(regWriteW), .resultSrcE_i(resultSrcE),
        .pcSrcE_i(pcSrcE),
        .stallF_o(stallF), .stallD_o(stallD),
        .flushD_o(flushD), .flushE_o(flushE),
        .forwardAE_o(fwdA), .forwardBE_o(fwdB),
        .stallCount_o(stallCnt), .flushCount_o(flushCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input bit we, input logic [AW-1:0] rd,
                               input logic [AW-1:0] rs);
        return we && rd != 0 && rd == rs;
    endfunction

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
`ifdef HAZARD_FORWARD_EN
        if (hit(regWriteM, RdM, rs)) return 2'b10;
        if (hit(regWriteW, RdW, rs)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        regWriteE = 0; regWriteM = 0; regWriteW = 0;
        resultSrcE = 0; pcSrcE = 0;
    endtask

    // Called after inputs are set (just after negedge); checks, then
    // advances the model across the next rising edge.
    task automatic cycle();
        bit lu, raw, haz, e_stall, e_flush;
        #1;
        lu  = resultSrcE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        raw = hit(regWriteE, RdE, Rs1D) || hit(regWriteE, RdE, Rs2D) ||
              hit(regWriteM, RdM, Rs1D) || hit(regWriteM, RdM, Rs2D) ||
              hit(regWriteW, RdW, Rs1D) || hit(regWriteW, RdW, Rs2D);
`ifdef HAZARD_FORWARD_EN
        haz = lu && !prev_lu;
`else
        haz = raw;
`endif
        e_flush = !rst && pcSrcE;
        e_stall = !rst && !pcSrcE && haz && !prev_rd;
        check("stallF", stallF, e_stall);
        check("stallD", stallD, e_stall);
        check("flushD", flushD, e_flush);
        check("flushE", flushE, e_flush | e_stall);
        check("fwdA", fwdA, fwd_ref(Rs1E));
        check("fwdB", fwdB, fwd_ref(Rs2E));
        check("stallCnt", stallCnt, m_stall_cnt);
        check("flushCnt", flushCnt, m_flush_cnt);
        @(posedge clk);
        if (rst) begin
            prev_lu = 0; prev_rd = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            prev_lu = e_stall;
            prev_rd = e_flush;
            if (e_stall && m_stall_cnt < CMAX) m_stall_cnt++;
            if (e_flush && m_flush_cnt < CMAX) m_flush_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        cycle();
        rst = 0;
        check("rstStallCnt", stallCnt, 0);
        check("rstFlushCnt", flushCnt, 0);

        // Reset applied in the middle of a load-use stall.
        RdE = 5; resultSrcE = 1; regWriteE = 1; Rs1D = 5;
        cycle();
        rst = 1;
        cycle();
        check("rstMidStall", stallD, 0);
        cycle();
        rst = 0;
        idle_inputs();
        #1;
        check("rstState", stallF | flushE, 0);
        check("rstCntS", stallCnt, 0);
        cycle();

        // Load-use followed by the bubble cycle with M forwarding.
        RdE = 5; resultSrcE = 1; regWriteE = 1; Rs1D = 5;
        #1;
        check("luStall", stallD, 1);
        check("luFlushE", flushE, 1);
        cycle();
        RdE = 0; resultSrcE = 0; regWriteE = 0;
        RdM = 5; regWriteM = 1; Rs1E = 5; Rs1D = 5;
`ifdef HAZARD_FORWARD_EN
        #1;
        check("luBubble", stallD, 0);
        check("luFwdA", fwdA, 2'b10);
`endif
        cycle();
        check("luCount", stallCnt, m_stall_cnt);
        idle_inputs();
        cycle();

        // Forward priority M over W, and x0 never forwards.
        RdM = 7; RdW = 7; regWriteM = 1; regWriteW = 1; Rs2E = 7;
`ifdef HAZARD_FORWARD_EN
        #1;
        check("fwdPriM", fwdB, 2'b10);
`endif
        cycle();
        regWriteM = 0;
`ifdef HAZARD_FORWARD_EN
        #1;
        check("fwdW", fwdB, 2'b01);
`endif
        cycle();
        Rs2E = 0; RdM = 0; RdW = 0; regWriteM = 1;
        #1;
        check("fwdX0", fwdB, 2'b00);
        cycle();
        idle_inputs();
        cycle();

        // Redirect wins over load-use in the same cycle.
        rst = 1;
        cycle();
        rst = 0;
        RdE = 4; resultSrcE = 1; regWriteE = 1; Rs2D = 4; pcSrcE = 1;
        #1;
        check("rdFlushD", flushD, 1);
        check("rdStallF", stallF, 0);
        cycle();
        check("rdFlushCnt", flushCnt, 1);
        check("rdStallCnt", stallCnt, 0);
        idle_inputs();
        cycle();

        // Saturation of the flush counter.
        pcSrcE = 1;
        for (int i = 0; i < 20; i++) cycle();
        check("flushSat", flushCnt, CMAX);
        idle_inputs();
        cycle();

`ifndef HAZARD_FORWARD_EN
        // Non-load producer walks E -> M -> W; decode stalls throughout.
        rst = 1;
        cycle();
        rst = 0;
        RdE = 3; regWriteE = 1; Rs2D = 3;
        #1;
        check("rawE", stallD, 1);
        cycle();
        RdE = 0; regWriteE = 0; RdM = 3; regWriteM = 1;
        #1;
        check("rawM", stallD, 1);
        cycle();
        RdM = 0; regWriteM = 0; RdW = 3; regWriteW = 1;
        #1;
        check("rawW", stallD, 1);
        check("rawFwd", {fwdA, fwdB}, 0);
        cycle();
        RdW = 0; regWriteW = 0;
        #1;
        check("rawDone", stallD, 0);
        check("rawCnt", stallCnt, 3);
        cycle();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            Rs1D = AW'($urandom_range(0, 3));
            Rs2D = AW'($urandom_range(0, 3));
            Rs1E = AW'($urandom_range(0, 3));
            Rs2E = AW'($urandom_range(0, 3));
            RdE = AW'($urandom_range(0, 3));
            RdM = AW'($urandom_range(0, 3));
            RdW = AW'($urandom_range(0, 3));
            regWriteE = 1'($urandom);
            regWriteM = 1'($urandom);
            regWriteW = 1'($urandom);
            resultSrcE = 1'($urandom);
            pcSrcE = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
